// File: rtl/step_seq_pkg.sv
// Shared step-sequencer constants: grid geometry, timing and draw FSM encoding.
package step_seq_pkg;

    localparam int         SS_TRACKS   = 4;
    localparam int         SS_STEPS    = 8;
    localparam logic [9:0] SS_X0       = 10'd80;
    localparam logic [8:0] SS_Y0       = 9'd100;
    localparam logic [9:0] SS_PITCH_X  = 10'd40;
    localparam logic [8:0] SS_PITCH_Y  = 9'd40;
    localparam int         SS_START_TO = 4;

    typedef enum logic [2:0] {
        SCAN,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        COMMIT
    } draw_fsm_e;

    function automatic logic [9:0] cell_x(
        input int         step,
        input logic [9:0] x0,
        input logic [9:0] px
    );
        int v;
        v = int'(x0) + step * int'(px);
        return v[9:0];
    endfunction

    function automatic logic [8:0] cell_y(
        input int         track,
        input logic [8:0] y0,
        input logic [8:0] py
    );
        int v;
        v = int'(y0) + track * int'(py);
        return v[8:0];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping upward.
module rr_pick #(
    parameter int N  = 32,
    parameter int IW = 5
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        int j;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        // Walk offsets from far to near so the nearest hit is written last.
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[IW'(j)]) begin
                idx   = IW'(j);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/grid_draw_scheduler.sv
// Schedules one-at-a-time redraws of dirty sequencer grid cells to a painter.
module grid_draw_scheduler
    import step_seq_pkg::*;
#(
    parameter int         TRACKS   = SS_TRACKS,
    parameter int         STEPS    = SS_STEPS,
    parameter logic [9:0] X0       = SS_X0,
    parameter logic [8:0] Y0       = SS_Y0,
    parameter logic [9:0] PITCH_X  = SS_PITCH_X,
    parameter logic [8:0] PITCH_Y  = SS_PITCH_Y,
    parameter int         START_TO = SS_START_TO
) (
    input  logic                     CLOCK_50,
    input  logic                     nReset,
    input  logic [TRACKS*STEPS-1:0]  pattern,
    input  logic                     full_refresh,
    input  logic                     drawing,
    output logic                     draw_enable,
    output logic [9:0]               X,
    output logic [8:0]               Y,
    output logic                     state,
    output logic                     busy,
    output logic                     synced
);

    localparam int N  = TRACKS * STEPS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(START_TO + 1);

    draw_fsm_e       fsm_q, fsm_d;
    logic [N-1:0]    shadow_q, shadow_d;
    logic [N-1:0]    force_q, force_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [9:0]      x_q, x_d;
    logic [8:0]      y_q, y_d;
    logic            drawn_val_q, drawn_val_d;
    logic [TW-1:0]   to_q, to_d;

    logic [N-1:0]    dirty;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;

    assign dirty = (pattern ^ shadow_q) | force_q;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req   (dirty),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        fsm_d       = fsm_q;
        shadow_d    = shadow_q;
        force_d     = force_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        x_d         = x_q;
        y_d         = y_q;
        drawn_val_d = drawn_val_q;
        to_d        = to_q;
        draw_enable = 1'b0;

        unique case (fsm_q)
            SCAN: begin
                if (pick_valid) begin
                    idx_d       = pick_idx;
                    x_d         = cell_x(int'(pick_idx) % STEPS, X0, PITCH_X);
                    y_d         = cell_y(int'(pick_idx) / STEPS, Y0, PITCH_Y);
                    drawn_val_d = pattern[pick_idx];
                    fsm_d       = ISSUE;
                end
            end
            ISSUE: begin
                draw_enable = 1'b1;
                to_d        = '0;
                fsm_d       = WAIT_START;
            end
            WAIT_START: begin
                if (drawing) begin
                    to_d  = '0;
                    fsm_d = WAIT_DONE;
                end else if (to_q == TW'(START_TO - 1)) begin
                    // Painter never started: drop back, cell stays dirty.
                    to_d  = '0;
                    fsm_d = SCAN;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!drawing) begin
                    fsm_d = COMMIT;
                end
            end
            COMMIT: begin
                shadow_d[idx_q] = drawn_val_q;
                force_d[idx_q]  = 1'b0;
                ptr_d = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
                fsm_d = SCAN;
            end
            default: begin
                fsm_d = SCAN;
            end
        endcase

        if (full_refresh) begin
            force_d = '1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!nReset) begin
            fsm_q       <= SCAN;
            shadow_q    <= '0;
            force_q     <= '1;
            ptr_q       <= '0;
            idx_q       <= '0;
            x_q         <= X0;
            y_q         <= Y0;
            drawn_val_q <= 1'b0;
            to_q        <= '0;
        end else begin
            fsm_q       <= fsm_d;
            shadow_q    <= shadow_d;
            force_q     <= force_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            y_q         <= y_d;
            drawn_val_q <= drawn_val_d;
            to_q        <= to_d;
        end
    end

    assign X      = x_q;
    assign Y      = y_q;
    assign state  = drawn_val_q;
    assign busy   = (fsm_q != SCAN);
    assign synced = (fsm_q == SCAN) && !(|dirty);

endmodule

// File: tb/tb_grid_draw_scheduler.sv
// Scoreboard bench for grid_draw_scheduler with a behavioural painter.
module tb_grid_draw_scheduler;

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic       s;
    } exp_t;

    logic        clk;
    logic        nReset;
    logic [31:0] pattern;
    logic        full_refresh;
    logic        drawing;
    logic        draw_enable;
    logic [9:0]  X;
    logic [8:0]  Y;
    logic        state;
    logic        busy;
    logic        synced;

    logic [31:0] pat;
    bit          paint_en;
    int          errs;
    int          checks;
    int          pulses;
    int          cyc;
    int          pulse_cyc[$];
    exp_t        sb[$];

    grid_draw_scheduler dut (
        .CLOCK_50     (clk),
        .nReset       (nReset),
        .pattern      (pattern),
        .full_refresh (full_refresh),
        .drawing      (drawing),
        .draw_enable  (draw_enable),
        .X            (X),
        .Y            (Y),
        .state        (state),
        .busy         (busy),
        .synced       (synced)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_cell(input int i, input logic s);
        exp_t e;
        e.x = 10'(80 + (i % 8) * 40);
        e.y = 9'(100 + (i / 8) * 40);
        e.s = s;
        sb.push_back(e);
    endtask

    task automatic set_bit(input int i, input logic v);
        pat[i]  = v;
        pattern = pat;
    endtask

    task automatic drain(input string tag, input int budget, output int n);
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            tick();
            n++;
            ok = (sb.size() == 0) && (synced === 1'b1);
        end
        chk({tag, "_drain"}, 32'(ok), 1);
    endtask

    task automatic wait_drawing(input logic v, input int budget);
        int  n;
        bit  ok;
        n  = 0;
        ok = (drawing === v);
        while (n < budget && !ok) begin
            tick();
            n++;
            ok = (drawing === v);
        end
        chk("wait_drawing", 32'(ok), 1);
    endtask

    // Painter: drawing rises one cycle after the start pulse, lasts 10 cycles.
    initial begin
        drawing = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (draw_enable === 1'b1 && paint_en) begin
                @(posedge clk);
                #1 drawing = 1'b1;
                repeat (10) @(posedge clk);
                #1 drawing = 1'b0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (draw_enable === 1'b1) begin
                pulses++;
                pulse_cyc.push_back(cyc);
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("pulse_x", 32'(X), 32'(e.x));
                    chk("pulse_y", 32'(Y), 32'(e.y));
                    chk("pulse_state", 32'(state), 32'(e.s));
                end
            end
        end
    end

    initial begin
        int n;
        int p0;
        int c0;
        int b;
        bit saw_sync;

        errs = 0;
        checks = 0;
        pulses = 0;
        paint_en = 1'b1;
        pat = '0;
        pattern = '0;
        full_refresh = 1'b0;
        nReset = 1'b0;

        repeat (3) tick();
        chk("rst_de", 32'(draw_enable), 0);
        chk("rst_x", 32'(X), 80);
        chk("rst_y", 32'(Y), 100);
        chk("rst_state", 32'(state), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_synced", 32'(synced), 0);

        for (int i = 0; i < 32; i++) push_cell(i, 1'b0);
        nReset = 1'b1;
        drain("init", 1000, n);
        chk("init_pulses", 32'(pulses), 32);

        p0 = pulses;
        c0 = cyc;
        set_bit(9, 1'b1);
        push_cell(9, 1'b1);
        drain("p9", 40, n);
        chk("p9_sync_lat", 32'(n <= 14), 1);
        chk("p9_pulses", 32'(pulses - p0), 1);
        chk("p9_de_lat", 32'(pulse_cyc[p0] - c0 <= 2), 1);

        set_bit(9, 1'b0);
        push_cell(9, 1'b0);
        drain("p9_clr", 40, n);

        p0 = pulses;
        set_bit(9, 1'b1);
        push_cell(9, 1'b1);
        wait_drawing(1'b1, 10);
        tick();
        chk("p9_in_wait_done", 32'(busy), 1);
        set_bit(9, 1'b0);
        push_cell(9, 1'b0);
        drain("p9_toggle", 80, n);
        chk("p9_toggle_pulses", 32'(pulses - p0), 2);

        paint_en = 1'b0;
        p0 = pulses;
        b = pulse_cyc.size();
        set_bit(2, 1'b1);
        for (int i = 0; i < 4; i++) push_cell(2, 1'b1);
        n = 0;
        saw_sync = 1'b0;
        while (n < 60 && pulses < p0 + 3) begin
            tick();
            n++;
            if (synced === 1'b1) saw_sync = 1'b1;
        end
        chk("retry_pulses", 32'(pulses - p0), 3);
        chk("retry_no_sync", 32'(saw_sync), 0);
        if (pulse_cyc.size() >= b + 3) begin
            chk("retry_gap0", 32'(pulse_cyc[b+1] - pulse_cyc[b]), 6);
            chk("retry_gap1", 32'(pulse_cyc[b+2] - pulse_cyc[b+1]), 6);
        end
        paint_en = 1'b1;
        drain("retry", 80, n);

        set_bit(20, 1'b1);
        push_cell(20, 1'b1);
        drain("c20", 40, n);
        set_bit(20, 1'b0);
        set_bit(3, 1'b1);
        push_cell(3, 1'b1);
        push_cell(20, 1'b0);
        drain("wrap", 80, n);
        set_bit(22, 1'b1);
        set_bit(3, 1'b0);
        push_cell(22, 1'b1);
        push_cell(3, 1'b0);
        drain("rr", 80, n);

        p0 = pulses;
        set_bit(5, 1'b1);
        push_cell(5, 1'b1);
        wait_drawing(1'b1, 10);
        wait_drawing(1'b0, 20);
        tick();
        chk("commit_busy", 32'(busy), 1);
        full_refresh = 1'b1;
        for (int i = 0; i < 32; i++) push_cell((6 + i) % 32, pat[(6 + i) % 32]);
        tick();
        full_refresh = 1'b0;
        drain("refresh", 700, n);
        chk("refresh_pulses", 32'(pulses - p0), 33);
        chk("final_synced", 32'(synced), 1);
        chk("final_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
